hm_scan_ctrl: RTL and testbench

Scan sequencer in the sys_clk domain that drives the host-memory (HM) engine one BAR at a time. It walks a software-supplied BAR mask lowest-index first. For each BAR it programs a one-hot BAR bitmap toward the trn domain, issues a start-read pulse, and waits for completion or timeout, retrying failed BARs. It returns a per-scan pass/fail map, counters and a done pulse to the CSR block.

---
 rtl/hm_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_hm_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hm_scan_ctrl.sv
// Scan sequencer for the host-memory engine: walks a BAR mask lowest-first, arms a
// one-hot bitmap, pulses start-read, and retries failed BARs up to MAX_RETRY times.
module hm_scan_ctrl #(
    parameter int unsigned SETTLE    = 8,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned WDOG      = 65535
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        scan_start,
    input  logic        scan_stop,
    input  logic [31:0] bar_mask,
    input  logic        lnk_up_n,
    input  logic        hm_end,
    input  logic        rx_timeout,
    input  logic        tx_timeout,
    input  logic        wr_timeout,
    output logic [31:0] bar_bitmap,
    output logic        hm_start_read,
    output logic        busy,
    output logic        scan_done,
    output logic [4:0]  cur_bar,
    output logic [31:0] fail_map,
    output logic [5:0]  ok_cnt,
    output logic [15:0] retry_cnt,
    output logic        link_err,
    output logic        abort_err
);

    localparam int unsigned SW = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);
    localparam logic [23:0]   WDOG_LD   = 24'(WDOG);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_ARM, S_START, S_WAIT, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   pending;
    logic [3:0]    tries;
    logic [SW-1:0] settle;
    logic [23:0]   wdog;
    logic [4:0]    low_idx;
    logic          active, abort, tmo;

    assign active = (state != S_IDLE) && (state != S_DONE);
    assign abort  = active && (lnk_up_n || scan_stop);
    assign tmo    = rx_timeout || tx_timeout || wr_timeout || (wdog == 24'd0);

    always_comb begin
        low_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (pending[i]) low_idx = 5'(i);
        end
    end

    // NOTE: state and datapath registers use non-blocking assignments only, so every
    // process sees the pre-edge values regardless of evaluation order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (scan_start) state_nxt = lnk_up_n ? S_DONE : S_SELECT;
            S_SELECT: state_nxt = (pending == '0) ? S_DONE : S_ARM;
            S_ARM:    if (settle == '0) state_nxt = S_START;
            S_START:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (hm_end)   state_nxt = S_SELECT;
                else if (tmo) state_nxt = (tries < RETRY_LIM) ? S_ARM : S_SELECT;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_DONE;
    end

    always_comb begin
        hm_start_read = (state == S_START);
        scan_done     = (state == S_DONE);
        busy          = active;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pending    <= '0;
            bar_bitmap <= '0;
            cur_bar    <= '0;
            fail_map   <= '0;
            ok_cnt     <= '0;
            retry_cnt  <= '0;
            link_err   <= 1'b0;
            abort_err  <= 1'b0;
            tries      <= '0;
            settle     <= '0;
            wdog       <= '0;
        end else begin
            if (abort) begin
                link_err  <= link_err  | lnk_up_n;
                abort_err <= abort_err | scan_stop;
            end else begin
                unique case (state)
                    S_IDLE: if (scan_start) begin
                        pending   <= bar_mask;
                        fail_map  <= '0;
                        ok_cnt    <= '0;
                        retry_cnt <= '0;
                        abort_err <= 1'b0;
                        link_err  <= lnk_up_n;
                    end
                    S_SELECT: if (pending != '0) begin
                        cur_bar    <= low_idx;
                        bar_bitmap <= 32'd1 << low_idx;
                        tries      <= '0;
                        settle     <= SETTLE_LD;
                    end
                    S_ARM:   if (settle != '0) settle <= settle - 1'b1;
                    S_START: wdog <= WDOG_LD;
                    S_WAIT: begin
                        if (wdog != '0) wdog <= wdog - 1'b1;
                        if (hm_end) begin
                            ok_cnt           <= ok_cnt + 1'b1;
                            pending[cur_bar] <= 1'b0;
                        end else if (tmo) begin
                            if (tries < RETRY_LIM) begin
                                tries  <= tries + 1'b1;
                                settle <= SETTLE_LD;
                                if (retry_cnt != 16'hFFFF) retry_cnt <= retry_cnt + 1'b1;
                            end else begin
                                fail_map[cur_bar] <= 1'b1;
                                pending[cur_bar]  <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            // Bitmap drops to zero as the scan enters DONE, whatever the reason.
            if (state_nxt == S_DONE) bar_bitmap <= '0;
        end
    end

endmodule

// File: tb/tb_hm_scan_ctrl.sv
// Self-checking bench for hm_scan_ctrl: directed and randomized scans compared
// against a per-BAR attempt model built from the scan rules.
module tb_hm_scan_ctrl;

    localparam int SETTLE    = 8;
    localparam int MAX_RETRY = 3;
    localparam int WDOG      = 100;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        scan_start = 1'b0, scan_stop = 1'b0;
    logic [31:0] bar_mask = '0;
    logic        lnk_up_n = 1'b0, hm_end = 1'b0;
    logic        rx_timeout = 1'b0, tx_timeout = 1'b0, wr_timeout = 1'b0;
    logic [31:0] bar_bitmap, fail_map;
    logic        hm_start_read, busy, scan_done, link_err, abort_err;
    logic [4:0]  cur_bar;
    logic [5:0]  ok_cnt;
    logic [15:0] retry_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    hm_scan_ctrl #(.SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY), .WDOG(WDOG)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .scan_start(scan_start), .scan_stop(scan_stop),
        .bar_mask(bar_mask), .lnk_up_n(lnk_up_n), .hm_end(hm_end),
        .rx_timeout(rx_timeout), .tx_timeout(tx_timeout), .wr_timeout(wr_timeout),
        .bar_bitmap(bar_bitmap), .hm_start_read(hm_start_read), .busy(busy),
        .scan_done(scan_done), .cur_bar(cur_bar), .fail_map(fail_map), .ok_cnt(ok_cnt),
        .retry_cnt(retry_cnt), .link_err(link_err), .abort_err(abort_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge sys_clk);
        cyc++;
    endtask

    task automatic wait_start();
        int n = 0;
        while (hm_start_read !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("start_seen", 32'(hm_start_read), 32'd1);
    endtask

    // Response per attempt: 0 hm_end, 1 timeout, 2 silent (watchdog), 3 hm_end+tx_timeout.
    function automatic int pick(input int mode, input int attempt);
        case (mode)
            0:       return 0;
            1:       return 1;
            2:       return (attempt == 0) ? 2 : 0;
            3:       return 3;
            default: return int'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic run_scan(input logic [31:0] mask, input int mode, input bit stop_too);
        logic [31:0] exp_fail = '0;
        int exp_ok = 0, exp_retry = 0;
        int next_at, done_at, last_start, ev, kind, n;
        bit prev_silent = 0, extra = 0;
        scan_start = 1'b1;
        scan_stop  = stop_too;
        bar_mask   = mask;
        next_at    = cyc + SETTLE + 2;
        done_at    = cyc + 2;
        tick();
        scan_start = 1'b0;
        scan_stop  = 1'b0;
        for (int b = 0; b < 32; b++) begin
            if (mask[b]) begin
                for (int t = 0; t <= MAX_RETRY; t++) begin
                    wait_start();
                    if (next_at >= 0) check("start_time", 32'(cyc), 32'(next_at));
                    if (prev_silent) check("wdog_gap", 32'(cyc - last_start >= WDOG), 32'd1);
                    check("bitmap", bar_bitmap, 32'd1 << b);
                    check("cur_bar", 32'(cur_bar), 32'(b));
                    check("busy_scan", 32'(busy), 32'd1);
                    last_start = cyc;
                    kind = pick(mode, t);
                    tick();
                    check("start_width", 32'(hm_start_read), 32'd0);
                    if (kind == 2) begin
                        prev_silent = 1;
                        next_at = -1;
                        done_at = -1;
                        if (t < MAX_RETRY) exp_retry++;
                        else exp_fail[b] = 1'b1;
                    end else begin
                        prev_silent = 0;
                        n = int'($urandom_range(0, 29));
                        repeat (n) tick();
                        hm_end = (kind == 0 || kind == 3);
                        tx_timeout = (kind == 3);
                        if (kind == 1) begin
                            case ($urandom_range(0, 2))
                                0:       rx_timeout = 1'b1;
                                1:       tx_timeout = 1'b1;
                                default: wr_timeout = 1'b1;
                            endcase
                        end
                        ev = cyc;
                        tick();
                        hm_end = 1'b0; rx_timeout = 1'b0; tx_timeout = 1'b0; wr_timeout = 1'b0;
                        done_at = ev + 2;
                        if (kind != 1) begin
                            exp_ok++;
                            next_at = ev + SETTLE + 2;
                            break;
                        end else if (t < MAX_RETRY) begin
                            exp_retry++;
                            next_at = ev + SETTLE + 1;
                        end else begin
                            exp_fail[b] = 1'b1;
                            next_at = ev + SETTLE + 2;
                        end
                    end
                end
            end
        end
        n = 0;
        while (scan_done !== 1'b1 && n < 400) begin
            if (hm_start_read === 1'b1) extra = 1;
            tick();
            n++;
        end
        check("done_seen", 32'(scan_done), 32'd1);
        if (done_at >= 0) check("done_time", 32'(cyc), 32'(done_at));
        check("extra_start", 32'(extra), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
        check("bitmap_at_done", bar_bitmap, 32'd0);
        check("ok_cnt", 32'(ok_cnt), 32'(exp_ok));
        check("fail_map", fail_map, exp_fail);
        check("retry_cnt", 32'(retry_cnt), 32'(exp_retry));
        check("link_err", 32'(link_err), 32'd0);
        check("abort_err", 32'(abort_err), 32'd0);
        tick();
        check("done_width", 32'(scan_done), 32'd0);
    endtask

    initial begin
        int n, starts, dones;
        logic [31:0] m;
        repeat (3) tick();
        check("rst_bitmap", bar_bitmap, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(scan_done), 32'd0);
        check("rst_start", 32'(hm_start_read), 32'd0);
        check("rst_counts", {fail_map[15:0], retry_cnt}, 32'd0);
        sys_rst = 1'b0;
        tick();

        run_scan(32'h0000_0005, 0, 1'b0);
        run_scan(32'h8000_0000, 1, 1'b0);
        run_scan(32'h0000_0003, 2, 1'b0);
        run_scan(32'h0000_0006, 3, 1'b1);
        run_scan(32'h0000_0000, 0, 1'b0);

        // Link drops while waiting on the first BAR.
        scan_start = 1'b1; bar_mask = 32'h3;
        tick();
        scan_start = 1'b0;
        wait_start();
        repeat (3) tick();
        lnk_up_n = 1'b1;
        tick();
        lnk_up_n = 1'b0;
        check("lnk_done", 32'(scan_done), 32'd1);
        check("lnk_err", 32'(link_err), 32'd1);
        check("lnk_bitmap", bar_bitmap, 32'd0);
        check("lnk_ok", 32'(ok_cnt), 32'd0);
        tick();

        // Link already down when the scan is accepted.
        lnk_up_n = 1'b1; scan_start = 1'b1; bar_mask = 32'h1;
        tick();
        lnk_up_n = 1'b0; scan_start = 1'b0;
        check("lnk_accept_done", 32'(scan_done), 32'd1);
        check("lnk_accept_err", 32'(link_err), 32'd1);
        tick();

        // Start while busy is ignored; stop during ARM aborts without a start pulse.
        scan_start = 1'b1; bar_mask = 32'h1;
        tick();
        scan_start = 1'b0;
        tick();
        scan_start = 1'b1; bar_mask = 32'hFFFF;
        tick();
        scan_start = 1'b0; scan_stop = 1'b1;
        tick();
        scan_stop = 1'b0;
        check("stop_done", 32'(scan_done), 32'd1);
        check("stop_abort_err", 32'(abort_err), 32'd1);
        check("stop_bitmap", bar_bitmap, 32'd0);
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (hm_start_read === 1'b1 || busy === 1'b1) starts++;
        end
        check("stop_quiet", 32'(starts), 32'd0);

        // Reset in the middle of WAIT.
        scan_start = 1'b1; bar_mask = 32'h10;
        tick();
        scan_start = 1'b0;
        wait_start();
        repeat (3) tick();
        sys_rst = 1'b1;
        tick();
        check("mid_rst_bitmap", bar_bitmap, 32'd0);
        check("mid_rst_cur_bar", 32'(cur_bar), 32'd0);
        check("mid_rst_flags", {26'd0, busy, scan_done, hm_start_read, link_err, abort_err, 1'b0}, 32'd0);
        sys_rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (scan_done === 1'b1) dones++;
        end
        check("mid_rst_no_done", 32'(dones), 32'd0);
        run_scan(32'h0000_0010, 0, 1'b0);

        // Randomized sparse masks with random responses.
        for (int k = 0; k < 3; k++) begin
            m = $urandom & $urandom & $urandom;
            run_scan(m, 4, 1'b0);
        end

        n = bad;
        $display("test done: total=%0d bad=%0d", total, n);
        $finish;
    end

endmodule
